fpu_exception_unit: RTL and testbench

Parametrised exception-tracking unit for the 8087-compatible FPU. It latches sticky exception flags from a configurable number of sources and applies per-source masks and a global interrupt-enable mask (IEM) before raising the interrupt request. It reports the highest-priority latched exception and, optionally, keeps a FIFO log of exception events with a caller-supplied tag. It sits between the FPU execution datapath and the status/control-word logic, and drives the FPU INT line.

---
 rtl/fpu_exc_pkg.sv | 33 +++
 rtl/fpu_exc_log_fifo.sv | 59 +++++
 rtl/fpu_exception_unit.sv | 101 ++++++++++
 tb/tb_fpu_exception_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_exc_pkg.sv
// Shared definitions for the FPU exception unit: exception indices, log entry
// record and the priority encoder used for the top-exception report.
package fpu_exc_pkg;

  localparam int EXC_IE = 0;
  localparam int EXC_DE = 1;
  localparam int EXC_ZE = 2;
  localparam int EXC_OE = 3;
  localparam int EXC_UE = 4;
  localparam int EXC_PE = 5;
  localparam int EXC_SF = 6;

  // Log entries are sized for the widest supported configuration (8 sources,
  // 32-bit tags); narrower instances zero-extend into them.
  localparam int EXC_MAX_W = 8;
  localparam int TAG_MAX_W = 32;

  typedef struct packed {
    logic [EXC_MAX_W-1:0] exc;
    logic [TAG_MAX_W-1:0] tag;
  } log_entry_t;

  // Index of the lowest set bit (bit 0 is highest priority); 0 when empty.
  function automatic logic [2:0] prio_enc(input logic [EXC_MAX_W-1:0] flags);
    logic [2:0] idx;
    idx = '0;
    for (int i = EXC_MAX_W - 1; i >= 0; i--) begin
      if (flags[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fpu_exc_log_fifo.sv
// Exception event log FIFO. A push into a full FIFO without a same-cycle pop is
// dropped and sets the sticky overflow flag.
module fpu_exc_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear_ovf,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   valid,
  output logic                   full,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_eff;
  logic             push_eff;
  logic             drop;

  assign valid    = (count != '0);
  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign pop_eff  = pop & valid;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push_eff = push & (~full | pop_eff);
  assign drop     = push & full & ~pop_eff;
  assign rdata    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= (overflow & ~clear_ovf) | drop;
    end
  end

endmodule

// File: rtl/fpu_exception_unit.sv
// FPU exception tracking: sticky flags, error-summary and INT generation, top
// exception report. Event log is built only when FPU_EXC_LOG_EN is defined.
module fpu_exception_unit
  import fpu_exc_pkg::*;
#(
  parameter int NUM_EXC   = 6,
  parameter int TAG_W     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_EXC-1:0]         exc_in,
  input  logic                       exc_latch,
  input  logic [NUM_EXC-1:0]         mask,
  input  logic                       iem,
  input  logic                       exc_clear,
  input  logic [TAG_W-1:0]           tag_in,
  input  logic                       log_pop,
  output logic                       int_request,
  output logic                       exception_pending,
  output logic [NUM_EXC-1:0]         latched_exceptions,
  output logic                       has_unmasked_exception,
  output logic                       top_exc_valid,
  output logic [2:0]                 top_exc_idx,
  output logic                       log_valid,
  output logic [NUM_EXC-1:0]         log_exc,
  output logic [TAG_W-1:0]           log_tag,
  output logic [$clog2(LOG_DEPTH):0] log_count,
  output logic                       log_overflow
);

  logic [NUM_EXC-1:0] latched_next;
  logic               es_next;
  logic               log_push;

  // Clear takes effect first so a coincident latch starts from an empty set.
  always_comb begin
    latched_next = exc_clear ? '0 : latched_exceptions;
    if (exc_latch) latched_next = latched_next | exc_in;
  end

  // ES only rises on a newly arriving unmasked exception, never on mask changes.
  assign es_next  = (exception_pending & ~exc_clear) | (exc_latch & |(exc_in & ~mask));
  assign log_push = exc_latch & |exc_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latched_exceptions <= '0;
      exception_pending  <= 1'b0;
      int_request        <= 1'b0;
    end else begin
      latched_exceptions <= latched_next;
      exception_pending  <= es_next;
      int_request        <= es_next & ~iem;
    end
  end

  assign has_unmasked_exception = |(latched_exceptions & ~mask);
  assign top_exc_valid          = |latched_exceptions;
  assign top_exc_idx            = prio_enc(EXC_MAX_W'(latched_exceptions));

`ifdef FPU_EXC_LOG_EN
  log_entry_t push_entry;
  log_entry_t log_head;
  logic       fifo_full;
  logic       unused_log;

  assign push_entry = '{exc: EXC_MAX_W'(exc_in), tag: TAG_MAX_W'(tag_in)};

  fpu_exc_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH ($bits(log_entry_t))
  ) u_log_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (log_push),
    .pop       (log_pop),
    .clear_ovf (exc_clear),
    .wdata     (push_entry),
    .valid     (log_valid),
    .full      (fifo_full),
    .rdata     (log_head),
    .count     (log_count),
    .overflow  (log_overflow)
  );

  assign log_exc    = log_head.exc[NUM_EXC-1:0];
  assign log_tag    = log_head.tag[TAG_W-1:0];
  assign unused_log = ^{fifo_full, log_head};
`else
  logic unused_log;

  assign log_valid    = 1'b0;
  assign log_exc      = '0;
  assign log_tag      = '0;
  assign log_count    = '0;
  assign log_overflow = 1'b0;
  assign unused_log   = ^{log_pop, tag_in, log_push};
`endif

endmodule

// File: tb/tb_fpu_exception_unit.sv
// Scoreboard bench for fpu_exception_unit: directed scenarios plus random
// traffic checked against a set/queue reference model.
module tb_fpu_exception_unit;

  localparam int NUM_EXC   = 6;
  localparam int TAG_W     = 16;
  localparam int LOG_DEPTH = 4;
`ifdef FPU_EXC_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic [NUM_EXC-1:0]         exc_in = '0;
  logic                       exc_latch = 1'b0;
  logic [NUM_EXC-1:0]         mask = '1;
  logic                       iem = 1'b1;
  logic                       exc_clear = 1'b0;
  logic [TAG_W-1:0]           tag_in = '0;
  logic                       log_pop = 1'b0;
  logic                       int_request;
  logic                       exception_pending;
  logic [NUM_EXC-1:0]         latched_exceptions;
  logic                       has_unmasked_exception;
  logic                       top_exc_valid;
  logic [2:0]                 top_exc_idx;
  logic                       log_valid;
  logic [NUM_EXC-1:0]         log_exc;
  logic [TAG_W-1:0]           log_tag;
  logic [$clog2(LOG_DEPTH):0] log_count;
  logic                       log_overflow;

  fpu_exception_unit #(.NUM_EXC(NUM_EXC), .TAG_W(TAG_W), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .exc_in                 (exc_in),
    .exc_latch              (exc_latch),
    .mask                   (mask),
    .iem                    (iem),
    .exc_clear              (exc_clear),
    .tag_in                 (tag_in),
    .log_pop                (log_pop),
    .int_request            (int_request),
    .exception_pending      (exception_pending),
    .latched_exceptions     (latched_exceptions),
    .has_unmasked_exception (has_unmasked_exception),
    .top_exc_valid          (top_exc_valid),
    .top_exc_idx            (top_exc_idx),
    .log_valid              (log_valid),
    .log_exc                (log_exc),
    .log_tag                (log_tag),
    .log_count              (log_count),
    .log_overflow           (log_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [5:0]  e;
    bit [15:0] t;
  } ent_t;

  typedef struct {
    bit        intr;
    bit        pend;
    bit [5:0]  lat;
    bit        unm;
    bit        tv;
    bit [2:0]  ti;
    bit        lv;
    bit [5:0]  le;
    bit [15:0] lt;
    int        lc;
    bit        lo;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: set of latched flags, ES bit, event log as a queue.
  bit [5:0] m_lat = '0;
  bit       m_es  = 1'b0;
  bit       m_ovf = 1'b0;
  ent_t     m_log[$];
  exp_t     exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("int_request", 32'(int_request), 32'(e.intr));
    chk("exception_pending", 32'(exception_pending), 32'(e.pend));
    chk("latched_exceptions", 32'(latched_exceptions), 32'(e.lat));
    chk("has_unmasked", 32'(has_unmasked_exception), 32'(e.unm));
    chk("top_exc_valid", 32'(top_exc_valid), 32'(e.tv));
    chk("top_exc_idx", 32'(top_exc_idx), 32'(e.ti));
    chk("log_valid", 32'(log_valid), 32'(e.lv));
    chk("log_exc", 32'(log_exc), 32'(e.le));
    chk("log_tag", 32'(log_tag), 32'(e.lt));
    chk("log_count", 32'(log_count), 32'(e.lc));
    chk("log_overflow", 32'(log_overflow), 32'(e.lo));
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, advance the model, queue
  // what the DUT must show after the following rising edge.
  task automatic step(input bit lat, input bit [5:0] ein, input bit [5:0] m, input bit ie,
                      input bit clr, input bit [15:0] tg, input bit pop);
    exp_t e;
    ent_t n;
    @(negedge clk);
    exc_latch = lat; exc_in = ein; mask = m; iem = ie;
    exc_clear = clr; tag_in = tg; log_pop = pop;
    if (clr) begin
      m_lat = '0; m_es = 1'b0; m_ovf = 1'b0;
    end
    if (lat) begin
      m_lat = m_lat | ein;
      if ((ein & ~m) != 0) m_es = 1'b1;
    end
    if (LOG_EN) begin
      if (pop && m_log.size() > 0) void'(m_log.pop_front());
      if (lat && ein != 0) begin
        n.e = ein; n.t = tg;
        if (m_log.size() < LOG_DEPTH) m_log.push_back(n);
        else m_ovf = 1'b1;
      end
    end
    e = zero_exp();
    e.intr = m_es & ~ie;
    e.pend = m_es;
    e.lat  = m_lat;
    e.unm  = (m_lat & ~m) != 0;
    e.tv   = m_lat != 0;
    for (int i = 0; i < 6; i++) begin
      if (m_lat[i]) begin
        e.ti = 3'(i);
        break;
      end
    end
    e.lv = m_log.size() > 0;
    if (e.lv) begin
      e.le = m_log[0].e;
      e.lt = m_log[0].t;
    end
    e.lc = m_log.size();
    e.lo = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit [5:0] m, input bit ie);
    step(1'b0, 6'h00, m, ie, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all(e);
      end
    end
  end

  initial begin : stim
    bit [5:0] rm;
    bit       rie;
    #2;
    chk_all(zero_exp());
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Latch while all masked, then unmasking must not raise ES.
    step(1'b1, 6'h01, 6'h3F, 1'b0, 1'b0, 16'h0, 1'b0);
    idle(6'h3E, 1'b0);
    idle(6'h3E, 1'b0);

    // Unmasked IE raises INT; iem gates it, masking never clears ES.
    step(1'b0, 6'h00, 6'h3E, 1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b1, 6'h01, 6'h3E, 1'b0, 1'b0, 16'h0, 1'b0);
    idle(6'h3E, 1'b1);
    idle(6'h3E, 1'b0);
    idle(6'h3F, 1'b0);
    step(1'b0, 6'h00, 6'h3F, 1'b0, 1'b1, 16'h0, 1'b0);

    // Accumulation and clear-with-latch.
    step(1'b1, 6'h01, 6'h00, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 6'h04, 6'h00, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 6'h30, 6'h00, 1'b0, 1'b1, 16'h0, 1'b0);
    idle(6'h00, 1'b0);

    // Log fill, overflow, pop+push while full, clear keeps entries.
    step(1'b0, 6'h00, 6'h3F, 1'b1, 1'b1, 16'h0, 1'b0);
    repeat (4) step(1'b0, 6'h00, 6'h3F, 1'b1, 1'b0, 16'h0, 1'b1);
    for (int t = 1; t <= 5; t++) step(1'b1, 6'h02, 6'h3F, 1'b1, 1'b0, 16'(t), 1'b0);
    step(1'b1, 6'h08, 6'h3F, 1'b1, 1'b0, 16'h6, 1'b1);
    step(1'b0, 6'h00, 6'h3F, 1'b1, 1'b1, 16'h0, 1'b0);
    step(1'b0, 6'h00, 6'h3F, 1'b1, 1'b0, 16'h0, 1'b1);

    // Asynchronous reset mid-stream with three log entries and INT high.
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 16'h0, 1'b0);
    repeat (4) step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int t = 1; t <= 3; t++) step(1'b1, 6'h01, 6'h00, 1'b0, 1'b0, 16'(t + 16), 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    exc_latch = 1'b0; exc_clear = 1'b0; log_pop = 1'b0; exc_in = '0;
    #1;
    chk_all(zero_exp());
    m_lat = '0; m_es = 1'b0; m_ovf = 1'b0;
    m_log.delete();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic.
    rm = 6'h00;
    rie = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rm = 6'($urandom);
      if ($urandom_range(0, 7) == 0) rie = 1'($urandom);
      step(1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom),
           rm, rie,
           $urandom_range(0, 15) == 0,
           16'($urandom),
           $urandom_range(0, 2) == 0);
    end
    idle(rm, rie);

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
